// File: rtl/id_stage_hazard.sv
// Decode stage: instruction decode, register file with write-through, RAW hazard interlock and ID/EX register.
// Build option ID_FORWARDING_EN: stall only on load-use against EX; otherwise full EX+MEM interlock.
module id_stage_hazard #(
  parameter int WORD_WIDTH = 32,
  parameter int REG_COUNT  = 16,
  parameter int REG_ADDR_W = 4,
  parameter int IMM_W      = 24,
  parameter int SHIFT_W    = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [WORD_WIDTH-1:0] i_pc_in,
  input  logic [WORD_WIDTH-1:0] i_instruction_in,
  input  logic                  i_if_valid,
  output logic                  o_id_ready,
  input  logic                  i_flush,
  input  logic                  i_ex_ready,
  input  logic [REG_ADDR_W-1:0] i_ex_dst,
  input  logic [REG_ADDR_W-1:0] i_mem_dst,
  input  logic                  i_ex_wb_en,
  input  logic                  i_mem_wb_en,
  input  logic                  i_ex_mem_read,
  input  logic                  i_wb_en_in,
  input  logic [REG_ADDR_W-1:0] i_wb_dest,
  input  logic [WORD_WIDTH-1:0] i_wb_data,
  output logic                  o_valid_out,
  output logic [WORD_WIDTH-1:0] o_pc_out,
  output logic [WORD_WIDTH-1:0] o_rn_val,
  output logic [WORD_WIDTH-1:0] o_rm_val,
  output logic [REG_ADDR_W-1:0] o_src1_out,
  output logic [REG_ADDR_W-1:0] o_src2_out,
  output logic [REG_ADDR_W-1:0] o_dst_out,
  output logic [IMM_W-1:0]      o_imm24_out,
  output logic [SHIFT_W-1:0]    o_shift_out,
  output logic [3:0]            o_ex_cmd,
  output logic                  o_mem_read,
  output logic                  o_mem_write,
  output logic                  o_wb_en,
  output logic                  o_imm,
  output logic                  o_b,
  output logic                  o_s
);

  logic [WORD_WIDTH-1:0] r_rf [REG_COUNT];

  logic [1:0]            w_mode;
  logic [3:0]            w_op;
  logic                  w_i_bit, w_s_bit;
  logic [3:0]            w_cmd;
  logic                  w_mr, w_mw, w_wb, w_imm, w_b, w_s;
  logic                  w_mov_mvn, w_uses_src1, w_uses_src2;
  logic [REG_ADDR_W-1:0] w_src1, w_src2;
  logic [WORD_WIDTH-1:0] w_rn, w_rm;
  logic                  w_match1, w_match2, w_hazard, w_bubble, w_unused;

  assign w_mode  = i_instruction_in[27:26];
  assign w_i_bit = i_instruction_in[25];
  assign w_op    = i_instruction_in[24:21];
  assign w_s_bit = i_instruction_in[20];

  always_comb begin
    w_cmd = 4'b0000;
    w_mr  = 1'b0;
    w_mw  = 1'b0;
    w_wb  = 1'b0;
    w_imm = 1'b0;
    w_b   = 1'b0;
    w_s   = 1'b0;
    case (w_mode)
      2'b00: begin
        w_s   = w_s_bit;
        w_imm = w_i_bit;
        w_wb  = 1'b1;
        case (w_op)
          4'b1101: w_cmd = 4'b0001;
          4'b1111: w_cmd = 4'b1001;
          4'b0100: w_cmd = 4'b0010;
          4'b0101: w_cmd = 4'b0011;
          4'b0010: w_cmd = 4'b0100;
          4'b0110: w_cmd = 4'b0101;
          4'b0000: w_cmd = 4'b0110;
          4'b1100: w_cmd = 4'b0111;
          4'b0001: w_cmd = 4'b1000;
          4'b1010: begin w_cmd = 4'b0100; w_wb = 1'b0; end
          4'b1000: begin w_cmd = 4'b0110; w_wb = 1'b0; end
          default: begin w_s = 1'b0; w_imm = 1'b0; w_wb = 1'b0; end
        endcase
      end
      2'b01: begin
        w_imm = w_i_bit;
        w_cmd = 4'b0010;
        w_mr  = w_s_bit;
        w_wb  = w_s_bit;
        w_mw  = !w_s_bit;
      end
      2'b10:   w_b = 1'b1;
      default: ;
    endcase
  end

  assign w_mov_mvn   = (w_mode == 2'b00) && ((w_op == 4'b1101) || (w_op == 4'b1111));
  assign w_uses_src1 = (w_mode != 2'b10) && !w_mov_mvn;
  assign w_uses_src2 = ((w_mode == 2'b00) && !w_i_bit) || w_mw;
  assign w_src1      = i_instruction_in[19:16];
  assign w_src2      = w_mw ? i_instruction_in[15:12] : i_instruction_in[3:0];

  // Write-through so an instruction decoded alongside its producer's write-back sees the new value.
  assign w_rn = (i_wb_en_in && (i_wb_dest == w_src1)) ? i_wb_data : r_rf[w_src1];
  assign w_rm = (i_wb_en_in && (i_wb_dest == w_src2)) ? i_wb_data : r_rf[w_src2];

`ifdef ID_FORWARDING_EN
  assign w_match1 = i_ex_mem_read && (i_ex_dst == w_src1);
  assign w_match2 = i_ex_mem_read && (i_ex_dst == w_src2);
  assign w_unused = ^{i_instruction_in[WORD_WIDTH-1:28], i_mem_dst, i_mem_wb_en, i_ex_wb_en};
`else
  assign w_match1 = (i_ex_wb_en && (i_ex_dst == w_src1)) || (i_mem_wb_en && (i_mem_dst == w_src1));
  assign w_match2 = (i_ex_wb_en && (i_ex_dst == w_src2)) || (i_mem_wb_en && (i_mem_dst == w_src2));
  assign w_unused = ^{i_instruction_in[WORD_WIDTH-1:28], i_ex_mem_read};
`endif

  assign w_hazard   = i_if_valid && ((w_uses_src1 && w_match1) || (w_uses_src2 && w_match2));
  assign o_id_ready = i_ex_ready && !w_hazard;
  assign w_bubble   = i_flush || w_hazard || !i_if_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < REG_COUNT; i++) r_rf[i] <= '0;
    end else if (i_wb_en_in) begin
      r_rf[i_wb_dest] <= i_wb_data;
    end
  end

  // Flush wins over a held register so a squashed instruction never reaches EX.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid_out <= 1'b0;
      o_pc_out    <= '0;
      o_rn_val    <= '0;
      o_rm_val    <= '0;
      o_src1_out  <= '0;
      o_src2_out  <= '0;
      o_dst_out   <= '0;
      o_imm24_out <= '0;
      o_shift_out <= '0;
      o_ex_cmd    <= '0;
      o_mem_read  <= 1'b0;
      o_mem_write <= 1'b0;
      o_wb_en     <= 1'b0;
      o_imm       <= 1'b0;
      o_b         <= 1'b0;
      o_s         <= 1'b0;
    end else if (i_ex_ready || i_flush) begin
      o_valid_out <= !w_bubble;
      o_pc_out    <= i_pc_in;
      o_rn_val    <= w_rn;
      o_rm_val    <= w_rm;
      o_src1_out  <= w_src1;
      o_src2_out  <= w_src2;
      o_dst_out   <= i_instruction_in[15:12];
      o_imm24_out <= i_instruction_in[IMM_W-1:0];
      o_shift_out <= i_instruction_in[SHIFT_W-1:0];
      o_ex_cmd    <= w_bubble ? 4'b0000 : w_cmd;
      o_mem_read  <= !w_bubble && w_mr;
      o_mem_write <= !w_bubble && w_mw;
      o_wb_en     <= !w_bubble && w_wb;
      o_imm       <= !w_bubble && w_imm;
      o_b         <= !w_bubble && w_b;
      o_s         <= !w_bubble && w_s;
    end
  end

endmodule

// File: tb/tb_id_stage_hazard.sv
// Scoreboard bench for id_stage_hazard: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_id_stage_hazard;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in, instr;
  logic        if_valid, flush, ex_ready;
  logic [3:0]  ex_dst, mem_dst, wb_dest;
  logic        ex_wb_en, mem_wb_en, ex_mem_read, wb_en_in;
  logic [31:0] wb_data;
  logic        id_ready;

  typedef struct packed {
    logic        valid;
    logic [3:0]  cmd;
    logic        mr, mw, wb, imm, b, s;
    logic [31:0] pc, rn, rm;
    logic [3:0]  src1, src2, dst;
    logic [23:0] imm24;
    logic [11:0] shift;
  } obs_t;

  typedef struct packed {
    obs_t o;
    logic chk_data;
  } exp_t;

  obs_t act;
  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  localparam logic [31:0] ADD = 32'hE0821003;  // ADD R1,R2,R3
  localparam logic [31:0] MOV = 32'hE3A06055;  // MOV R6,#0x55
  localparam logic [31:0] CMP = 32'hE1510002;  // CMP R1,R2 (S=1)
  localparam logic [31:0] STR = 32'hE5854000;  // STR R4,[R5]
  localparam logic [31:0] LDR = 32'hE5927000;  // LDR R7,[R2]
  localparam logic [31:0] BR  = 32'hEA000010;
  localparam logic [31:0] M11 = 32'hEC000000;
  localparam logic [31:0] RSB = 32'hE0621003;  // unlisted data-processing op
  localparam logic [31:0] SUB = 32'hE0421003;

  id_stage_hazard dut (
    .i_clk(clk), .i_rst(rst), .i_pc_in(pc_in), .i_instruction_in(instr),
    .i_if_valid(if_valid), .o_id_ready(id_ready), .i_flush(flush), .i_ex_ready(ex_ready),
    .i_ex_dst(ex_dst), .i_mem_dst(mem_dst), .i_ex_wb_en(ex_wb_en), .i_mem_wb_en(mem_wb_en),
    .i_ex_mem_read(ex_mem_read), .i_wb_en_in(wb_en_in), .i_wb_dest(wb_dest), .i_wb_data(wb_data),
    .o_valid_out(act.valid), .o_pc_out(act.pc), .o_rn_val(act.rn), .o_rm_val(act.rm),
    .o_src1_out(act.src1), .o_src2_out(act.src2), .o_dst_out(act.dst),
    .o_imm24_out(act.imm24), .o_shift_out(act.shift), .o_ex_cmd(act.cmd),
    .o_mem_read(act.mr), .o_mem_write(act.mw), .o_wb_en(act.wb), .o_imm(act.imm),
    .o_b(act.b), .o_s(act.s)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [3:0] cmd, input logic mr, mw, wb, im, b, s,
                              input logic [31:0] pc, ins, rn, rm, input logic [3:0] src2);
    exp_t e;
    e.chk_data = 1'b1;
    e.o = '{valid: 1'b1, cmd: cmd, mr: mr, mw: mw, wb: wb, imm: im, b: b, s: s,
            pc: pc, rn: rn, rm: rm, src1: ins[19:16], src2: src2, dst: ins[15:12],
            imm24: ins[23:0], shift: ins[11:0]};
    return e;
  endfunction

  function automatic exp_t bubble();
    exp_t e;
    e = '0;
    return e;
  endfunction

  function automatic exp_t zeros();
    exp_t e;
    e = '0;
    e.chk_data = 1'b1;
    return e;
  endfunction

  // Inputs are already driven; check combinational ready, queue the registered result, advance a cycle.
  task automatic cyc(input exp_t e, input logic rdy_exp, input string name);
    #1;
    tests++;
    if (id_ready !== rdy_exp) begin
      fails++;
      $display("FAIL %s id_ready: got %b want %b", name, id_ready, rdy_exp);
    end
    q.push_back(e);
    @(posedge clk);
    #3;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (e.chk_data) begin
          if (act !== e.o) begin
            fails++;
            $display("FAIL out_full: got %h want %h", act, e.o);
          end
        end else if ({act.valid, act.cmd, act.mr, act.mw, act.wb, act.imm, act.b, act.s} !==
                     {e.o.valid, e.o.cmd, e.o.mr, e.o.mw, e.o.wb, e.o.imm, e.o.b, e.o.s}) begin
          fails++;
          $display("FAIL out_ctrl: got v=%b cmd=%h mr%b mw%b wb%b i%b b%b s%b want v=%b cmd=%h",
                   act.valid, act.cmd, act.mr, act.mw, act.wb, act.imm, act.b, act.s,
                   e.o.valid, e.o.cmd);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; pc_in = '0; instr = '0; if_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    ex_dst = '0; mem_dst = '0; ex_wb_en = 1'b0; mem_wb_en = 1'b0; ex_mem_read = 1'b0;
    wb_en_in = 1'b0; wb_dest = '0; wb_data = '0;
    @(posedge clk);
    #3;
    cyc(zeros(), 1'b1, "reset");
    rst = 1'b0;

    wb_en_in = 1'b1; wb_dest = 4'd2; wb_data = 32'd5;
    cyc(bubble(), 1'b1, "wr_r2");
    wb_dest = 4'd3; wb_data = 32'd7;
    cyc(bubble(), 1'b1, "wr_r3");
    wb_en_in = 1'b0;

    if_valid = 1'b1; pc_in = 32'h100; instr = ADD;
    cyc(mk(4'b0010, 0, 0, 1, 0, 0, 0, 32'h100, ADD, 5, 7, 4'd3), 1'b1, "add");
    pc_in = 32'h104; wb_en_in = 1'b1; wb_dest = 4'd2; wb_data = 32'd9;
    cyc(mk(4'b0010, 0, 0, 1, 0, 0, 0, 32'h104, ADD, 9, 7, 4'd3), 1'b1, "wr_through");
    wb_en_in = 1'b0;
    pc_in = 32'h108; instr = MOV;
    cyc(mk(4'b0001, 0, 0, 1, 1, 0, 0, 32'h108, MOV, 0, 0, 4'd5), 1'b1, "mov");
    pc_in = 32'h10C; instr = CMP;
    cyc(mk(4'b0100, 0, 0, 0, 0, 0, 1, 32'h10C, CMP, 0, 9, 4'd2), 1'b1, "cmp");
    pc_in = 32'h110; instr = STR;
    cyc(mk(4'b0010, 0, 1, 0, 0, 0, 0, 32'h110, STR, 0, 0, 4'd4), 1'b1, "str");
    pc_in = 32'h114; instr = LDR;
    cyc(mk(4'b0010, 1, 0, 1, 0, 0, 0, 32'h114, LDR, 9, 0, 4'd0), 1'b1, "ldr");
    pc_in = 32'h118; instr = BR;
    cyc(mk(4'b0000, 0, 0, 0, 0, 1, 0, 32'h118, BR, 0, 0, 4'd0), 1'b1, "branch");
    pc_in = 32'h11C; instr = M11;
    cyc(mk(4'b0000, 0, 0, 0, 0, 0, 0, 32'h11C, M11, 0, 0, 4'd0), 1'b1, "mode11");
    pc_in = 32'h120; instr = RSB;
    cyc(mk(4'b0000, 0, 0, 0, 0, 0, 0, 32'h120, RSB, 9, 7, 4'd3), 1'b1, "unlisted_op");

    // MOV #imm reads no registers, so a pending write to R0 must not stall it.
    pc_in = 32'h124; instr = MOV; ex_dst = 4'd0; ex_wb_en = 1'b1; ex_mem_read = 1'b1;
    cyc(mk(4'b0001, 0, 0, 1, 1, 0, 0, 32'h124, MOV, 0, 0, 4'd5), 1'b1, "mov_no_src");
    ex_mem_read = 1'b0;

    pc_in = 32'h200; instr = ADD; ex_dst = 4'd2; ex_wb_en = 1'b1;
`ifdef ID_FORWARDING_EN
    cyc(mk(4'b0010, 0, 0, 1, 0, 0, 0, 32'h200, ADD, 9, 7, 4'd3), 1'b1, "fwd_no_stall");
    ex_mem_read = 1'b1;
    cyc(bubble(), 1'b0, "load_use");
    ex_mem_read = 1'b0; ex_wb_en = 1'b0; mem_dst = 4'd2; mem_wb_en = 1'b1;
    cyc(mk(4'b0010, 0, 0, 1, 0, 0, 0, 32'h200, ADD, 9, 7, 4'd3), 1'b1, "load_use_rel");
`else
    cyc(bubble(), 1'b0, "raw_ex");
    ex_wb_en = 1'b0; mem_dst = 4'd2; mem_wb_en = 1'b1;
    cyc(bubble(), 1'b0, "raw_mem");
    mem_wb_en = 1'b0;
    cyc(mk(4'b0010, 0, 0, 1, 0, 0, 0, 32'h200, ADD, 9, 7, 4'd3), 1'b1, "raw_release");
`endif
    ex_wb_en = 1'b0; mem_wb_en = 1'b0;

    pc_in = 32'h300; instr = ADD;
    cyc(mk(4'b0010, 0, 0, 1, 0, 0, 0, 32'h300, ADD, 9, 7, 4'd3), 1'b1, "pre_hold");
    ex_ready = 1'b0; pc_in = 32'h304; instr = SUB;
    for (int k = 0; k < 3; k++)
      cyc(mk(4'b0010, 0, 0, 1, 0, 0, 0, 32'h300, ADD, 9, 7, 4'd3), 1'b0, "hold");
    flush = 1'b1;
    cyc(bubble(), 1'b0, "flush_hold");
    flush = 1'b0; ex_ready = 1'b1; if_valid = 1'b0;
    cyc(bubble(), 1'b1, "idle");

    if_valid = 1'b1; pc_in = 32'h400; instr = ADD;
    cyc(mk(4'b0010, 0, 0, 1, 0, 0, 0, 32'h400, ADD, 9, 7, 4'd3), 1'b1, "pre_rst");
    ex_dst = 4'd2; ex_wb_en = 1'b1; ex_mem_read = 1'b1;
    cyc(bubble(), 1'b0, "stall");
    rst = 1'b1;
    cyc(zeros(), 1'b0, "rst_stall");
    rst = 1'b0; ex_wb_en = 1'b0; ex_mem_read = 1'b0; pc_in = 32'h404;
    cyc(mk(4'b0010, 0, 0, 1, 0, 0, 0, 32'h404, ADD, 0, 0, 4'd3), 1'b1, "rf_cleared");
    if_valid = 1'b0;

    repeat (3) @(posedge clk);
    #3;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
